// File: rtl/univ_shift_reg_if.sv
// Bundles the control, data and result signals of univ_shift_reg.
// The master drives the operation; the slave (the register) returns its state.
interface univ_shift_reg_if #(
    parameter int unsigned WIDTH = 8
);
    logic             e;
    logic [2:0]       mode;
    logic [WIDTH-1:0] d;
    logic             sin_l;
    logic             sin_r;
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] qbar;
    logic             cout;
    logic             zero;

    modport master (
        output e, mode, d, sin_l, sin_r,
        input  q, qbar, cout, zero
    );

    modport slave (
        input  e, mode, d, sin_l, sin_r,
        output q, qbar, cout, zero
    );
endinterface

// File: rtl/univ_shift_reg.sv
// Multi-mode WIDTH-bit register: hold, load, shift, rotate, increment and
// decrement, with a registered carry/shift-out flag and complementary outputs.
module univ_shift_reg #(
    parameter int unsigned     WIDTH     = 8,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input logic              clk,
    input logic              r,
    univ_shift_reg_if.slave  bus
);

    typedef enum logic [2:0] {
        ModeHold = 3'b000,
        ModeLoad = 3'b001,
        ModeShl  = 3'b010,
        ModeShr  = 3'b011,
        ModeRol  = 3'b100,
        ModeRor  = 3'b101,
        ModeInc  = 3'b110,
        ModeDec  = 3'b111
    } mode_e;

    logic [WIDTH-1:0] q_q, q_d;
    logic             cout_q, cout_d;
    mode_e            mode;

    assign mode = mode_e'(bus.mode);

    // Next-state selection; disabled cycles fall through to hold.
    always_comb begin
        q_d    = q_q;
        cout_d = cout_q;
        if (bus.e) begin
            unique case (mode)
                ModeHold: begin
                    q_d    = q_q;
                    cout_d = cout_q;
                end
                ModeLoad: begin
                    q_d    = bus.d;
                    cout_d = 1'b0;
                end
                ModeShl: begin
                    q_d    = {q_q[WIDTH-2:0], bus.sin_l};
                    cout_d = q_q[WIDTH-1];
                end
                ModeShr: begin
                    q_d    = {bus.sin_r, q_q[WIDTH-1:1]};
                    cout_d = q_q[0];
                end
                ModeRol: begin
                    q_d    = {q_q[WIDTH-2:0], q_q[WIDTH-1]};
                    cout_d = q_q[WIDTH-1];
                end
                ModeRor: begin
                    q_d    = {q_q[0], q_q[WIDTH-1:1]};
                    cout_d = q_q[0];
                end
                ModeInc: begin
                    // Carry is the extra top bit of the widened sum.
                    {cout_d, q_d} = {1'b0, q_q} + {{WIDTH{1'b0}}, 1'b1};
                end
                ModeDec: begin
                    q_d    = q_q - {{(WIDTH-1){1'b0}}, 1'b1};
                    cout_d = (q_q == '0);
                end
            endcase
        end
    end

    // State register with synchronous active-low reset taking priority.
    always_ff @(posedge clk) begin
        if (!r) begin
            q_q    <= RESET_VAL;
            cout_q <= 1'b0;
        end else begin
            q_q    <= q_d;
            cout_q <= cout_d;
        end
    end

    assign bus.q    = q_q;
    assign bus.qbar = ~q_q;
    assign bus.cout = cout_q;
    assign bus.zero = (q_q == '0);

endmodule

// File: tb/tb_univ_shift_reg.sv
// Bench for univ_shift_reg: three instances (8-bit reset-to-0, 8-bit reset-to-3C,
// 3-bit reset-to-5) share one stimulus stream and are checked against a model.
module tb_univ_shift_reg;

    logic       clk;
    logic       r;
    logic       e;
    logic [2:0] mode;
    logic [7:0] d;
    logic       sin_l;
    logic       sin_r;

    int tests;
    int failures;
    bit started;

    univ_shift_reg_if #(.WIDTH(8)) bus8 ();
    univ_shift_reg_if #(.WIDTH(8)) bus8r ();
    univ_shift_reg_if #(.WIDTH(3)) bus3 ();

    assign bus8.e = e;     assign bus8.mode = mode;  assign bus8.d = d;
    assign bus8.sin_l = sin_l;  assign bus8.sin_r = sin_r;
    assign bus8r.e = e;    assign bus8r.mode = mode; assign bus8r.d = d;
    assign bus8r.sin_l = sin_l; assign bus8r.sin_r = sin_r;
    assign bus3.e = e;     assign bus3.mode = mode;  assign bus3.d = d[2:0];
    assign bus3.sin_l = sin_l;  assign bus3.sin_r = sin_r;

    univ_shift_reg #(.WIDTH(8), .RESET_VAL(8'h00)) dut8 (
        .clk (clk),
        .r   (r),
        .bus (bus8)
    );
    univ_shift_reg #(.WIDTH(8), .RESET_VAL(8'h3C)) dut8r (
        .clk (clk),
        .r   (r),
        .bus (bus8r)
    );
    univ_shift_reg #(.WIDTH(3), .RESET_VAL(3'b101)) dut3 (
        .clk (clk),
        .r   (r),
        .bus (bus3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Mode must be known whenever it is acted upon.
    always @(posedge clk) begin
        if (started && r === 1'b1 && e === 1'b1)
            assert (!$isunknown(mode)) else $error("FAIL mode_known: mode=%b", mode);
    end

    // Complement invariant on every cycle, sampled away from the edge.
    always @(negedge clk) begin
        if (started)
            assert (bus8.qbar === ~bus8.q && bus8r.qbar === ~bus8r.q && bus3.qbar === ~bus3.q)
            else $error("FAIL qbar_invariant: q8=%h qbar8=%h q3=%h qbar3=%h",
                        bus8.q, bus8.qbar, bus3.q, bus3.qbar);
    end

    // Reference model on a byte, masked to width w. Returns {cout, q}.
    function automatic logic [8:0] model_next(input logic [7:0] cq, input logic cc,
                                              input int w, input bit rr, input bit ee,
                                              input logic [2:0] mm, input logic [7:0] dd,
                                              input bit sl, input bit sr,
                                              input logic [7:0] rv);
        logic [7:0] mask;
        logic [7:0] nq;
        logic       nc;
        mask = 8'((9'd1 << w) - 9'd1);
        nq = cq;
        nc = cc;
        if (!rr) begin
            nq = rv & mask;
            nc = 1'b0;
        end else if (ee) begin
            case (mm)
                3'd1: begin nq = dd & mask; nc = 1'b0; end
                3'd2: begin nc = cq[w-1]; nq = ((cq << 1) | {7'b0, sl}) & mask; end
                3'd3: begin nc = cq[0]; nq = (cq >> 1) | (8'(sr) << (w - 1)); end
                3'd4: begin nc = cq[w-1]; nq = ((cq << 1) | {7'b0, cq[w-1]}) & mask; end
                3'd5: begin nc = cq[0]; nq = (cq >> 1) | (8'(cq[0]) << (w - 1)); end
                3'd6: begin
                    if (cq == mask) begin nq = 8'h00; nc = 1'b1; end
                    else begin nq = cq + 8'd1; nc = 1'b0; end
                end
                3'd7: begin
                    if (cq == 8'h00) begin nq = mask; nc = 1'b1; end
                    else begin nq = cq - 8'd1; nc = 1'b0; end
                end
                default: ;
            endcase
        end
        return {nc, nq};
    endfunction

    task automatic chk(input string name, input logic [8:0] act, input logic [8:0] exp);
        tests++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    typedef struct {
        string      name;
        logic [8:0] e8;
        logic [8:0] e8r;
        logic [8:0] e3;
    } sb_t;

    sb_t sb_q[$];

    logic [7:0] m8q, m8rq, m3q;
    logic       m8c, m8rc, m3c;

    // Drive one cycle of stimulus, queue the model's prediction, then check after the edge.
    task automatic apply(input string name, input bit rr, input bit ee, input logic [2:0] mm,
                         input logic [7:0] dd, input bit sl, input bit sr);
        sb_t        s;
        logic [8:0] n;
        r = rr; e = ee; mode = mm; d = dd; sin_l = sl; sin_r = sr;
        n = model_next(m8q, m8c, 8, rr, ee, mm, dd, sl, sr, 8'h00);
        m8q = n[7:0]; m8c = n[8]; s.e8 = n;
        n = model_next(m8rq, m8rc, 8, rr, ee, mm, dd, sl, sr, 8'h3C);
        m8rq = n[7:0]; m8rc = n[8]; s.e8r = n;
        n = model_next(m3q, m3c, 3, rr, ee, mm, dd, sl, sr, 8'h05);
        m3q = n[7:0]; m3c = n[8]; s.e3 = n;
        s.name = name;
        sb_q.push_back(s);
        @(posedge clk);
        #1;
        started = 1'b1;
        if (sb_q.size() == 0) begin
            chk({name, " scoreboard_empty"}, 9'd0, 9'd1);
        end else begin
            s = sb_q.pop_front();
            chk({s.name, " dut8"}, {bus8.cout, bus8.q}, s.e8);
            chk({s.name, " dut8r"}, {bus8r.cout, bus8r.q}, s.e8r);
            chk({s.name, " dut3"}, {bus3.cout, 5'b0, bus3.q}, s.e3);
            chk({s.name, " zero8"}, {8'b0, bus8.zero}, {8'b0, s.e8[7:0] == 8'h00});
            chk({s.name, " zero3"}, {8'b0, bus3.zero}, {8'b0, s.e3[2:0] == 3'b000});
            chk({s.name, " qbar8"}, {1'b0, bus8.qbar}, {1'b0, ~s.e8[7:0]});
            chk({s.name, " qbar3"}, {6'b0, bus3.qbar}, {6'b0, ~s.e3[2:0]});
        end
    endtask

    typedef struct {
        string      name;
        bit         rr;
        bit         ee;
        logic [2:0] mm;
        logic [7:0] dd;
        bit         sl;
        bit         sr;
        logic [7:0] xq;
        bit         xc;
        bit         xz;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(input string nm, input bit rr, input bit ee, input logic [2:0] mm,
                                input logic [7:0] dd, input bit sl, input bit sr,
                                input logic [7:0] xq, input bit xc, input bit xz);
        vec_t v;
        v.name = nm; v.rr = rr; v.ee = ee; v.mm = mm; v.dd = dd; v.sl = sl; v.sr = sr;
        v.xq = xq; v.xc = xc; v.xz = xz;
        vecs.push_back(v);
    endfunction

    initial begin
        tests = 0;
        failures = 0;
        started = 1'b0;
        m8q = 8'h00; m8rq = 8'h00; m3q = 8'h00;
        m8c = 1'b0;  m8rc = 1'b0;  m3c = 1'b0;
        r = 1'b0; e = 1'b0; mode = 3'd0; d = 8'h00; sin_l = 1'b0; sin_r = 1'b0;

        // Expected values below are for the 8-bit, reset-to-0 instance.
        //   name        r  e  mode  d      sl sr  q      c  z
        add("reset",     0, 1, 3'd1, 8'hA5, 0, 0, 8'h00, 0, 1);
        add("load_5a",   1, 1, 3'd1, 8'h5A, 0, 0, 8'h5A, 0, 0);
        add("gate0",     1, 0, 3'd2, 8'h00, 1, 1, 8'h5A, 0, 0);
        add("gate1",     1, 0, 3'd2, 8'hFF, 1, 1, 8'h5A, 0, 0);
        add("gate2",     1, 0, 3'd2, 8'h00, 0, 0, 8'h5A, 0, 0);
        add("gate3",     1, 0, 3'd2, 8'h33, 1, 0, 8'h5A, 0, 0);
        add("load_81",   1, 1, 3'd1, 8'h81, 0, 0, 8'h81, 0, 0);
        add("shl",       1, 1, 3'd2, 8'h00, 0, 0, 8'h02, 1, 0);
        add("shr",       1, 1, 3'd3, 8'h00, 0, 1, 8'h81, 0, 0);
        add("ror",       1, 1, 3'd5, 8'h00, 0, 0, 8'hC0, 1, 0);
        add("load_fe",   1, 1, 3'd1, 8'hFE, 0, 0, 8'hFE, 0, 0);
        add("inc_ff",    1, 1, 3'd6, 8'h00, 0, 0, 8'hFF, 0, 0);
        add("inc_wrap",  1, 1, 3'd6, 8'h00, 0, 0, 8'h00, 1, 1);
        add("dec_wrap",  1, 1, 3'd7, 8'h00, 0, 0, 8'hFF, 1, 0);
        add("dec_fe",    1, 1, 3'd7, 8'h00, 0, 0, 8'hFE, 0, 0);
        add("rol",       1, 1, 3'd4, 8'h00, 0, 0, 8'hFD, 1, 0);
        add("hold",      1, 1, 3'd0, 8'h12, 1, 1, 8'hFD, 1, 0);

        foreach (vecs[i]) begin
            apply(vecs[i].name, vecs[i].rr, vecs[i].ee, vecs[i].mm, vecs[i].dd,
                  vecs[i].sl, vecs[i].sr);
            chk({vecs[i].name, " tbl_q_cout"}, {bus8.cout, bus8.q}, {vecs[i].xc, vecs[i].xq});
            chk({vecs[i].name, " tbl_zero"}, {8'b0, bus8.zero}, {8'b0, vecs[i].xz});
            chk({vecs[i].name, " tbl_qbar"}, {1'b0, bus8.qbar}, {1'b0, ~vecs[i].xq});
            if (i == 0) begin
                chk("reset_val_3c", {bus8r.cout, bus8r.q}, {1'b0, 8'h3C});
                chk("reset_val_w3", {bus3.cout, 5'b0, bus3.q}, {1'b0, 8'h05});
            end
        end

        // Reset aborts a shift sequence; the next held cycle keeps the reset value.
        apply("mid_load", 1, 1, 3'd1, 8'hF0, 0, 0);
        apply("mid_shl1", 1, 1, 3'd2, 8'h00, 0, 0);
        chk("mid_shl1 q", {bus8.cout, bus8.q}, {1'b1, 8'hE0});
        apply("mid_shl2", 1, 1, 3'd2, 8'h00, 0, 0);
        chk("mid_shl2 q", {bus8.cout, bus8.q}, {1'b1, 8'hC0});
        apply("mid_rst", 0, 1, 3'd2, 8'h00, 1, 1);
        chk("mid_rst q", {bus8.cout, bus8.q}, {1'b0, 8'h00});
        chk("mid_rst q_3c", {bus8r.cout, bus8r.q}, {1'b0, 8'h3C});
        apply("mid_hold", 1, 1, 3'd0, 8'hAA, 1, 1);
        chk("mid_hold q_3c", {bus8r.cout, bus8r.q}, {1'b0, 8'h3C});

        // Random traffic with occasional resets.
        for (int k = 0; k < 2000; k++) begin
            apply("rand", ($urandom_range(15) != 0), ($urandom_range(3) != 0),
                  3'($urandom_range(7)), 8'($urandom), 1'($urandom), 1'($urandom));
        end

        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end

    // Absolute time bound in case the stimulus thread stalls.
    initial begin
        #500000;
        $display("FAIL timeout: simulation exceeded time budget");
        $fatal(1, "timeout");
    end

endmodule
